serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial unsigned/two's-complement subtractor built around a single full-subtractor cell and a borrow flip-flop. It is the inverse-operation companion to the team's full adder and computes `diff = a - b` LSB-first over WIDTH cycles. Operands arrive and results leave through valid/ready handshakes, so the block can sit between stream stages in area-constrained datapaths.

## Interface
- `WIDTH`, default 8: operand and result width in bits, minimum 1.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `in_valid`  input  1  operand pair valid.
- `in_ready`  output  1  block can accept operands.
- `a`  input  WIDTH  minuend, sampled only on the input handshake.
- `b`  input  WIDTH  subtrahend, sampled only on the input handshake.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts the result.
- `diff`  output  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow_out`  output  1  final borrow; 1 when `a < b` unsigned.
- `overflow`  output  1  signed overflow: `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.
- `busy`  output  1  high in RUN and DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready` at an edge: latch `a` and `b` into shift registers, clear the bit counter and the borrow flop, then go to RUN.
- **RUN**, one bit per cycle, for bit i (LSB first):
  - `d_i = a_i ^ b_i ^ br`
  - `br' = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
  - `d_i` shifts into the result register from the MSB side. The operand registers shift right.
  - After the WIDTH-th RUN edge: load `diff`, `borrow_out` = final `br`, compute `overflow`, set `out_valid`, and go to DONE.
- **DONE**
  - `diff`, `borrow_out` and `overflow` are held stable while `out_valid` = 1.
  - On `out_valid && out_ready`: clear `out_valid` and go to IDLE.
  - `diff`, `borrow_out` and `overflow` keep their last values after the transfer; they are don't-care when `out_valid` = 0.
- `in_ready` = 0 in RUN and DONE. `in_valid` is ignored there, and the source must hold it.
- Result bits shift in MSB-side so that after WIDTH shifts, bit 0 of `diff` is the first computed bit.
- `WIDTH` = 1 is legal: RUN lasts one cycle, and `overflow = a ^ b ^ ... ` reduces to the formula above applied to bit 0.

## Timing
- Reset values (next edge with `rst` = 1):
  - `in_ready` 1
  - `out_valid` 0
  - `diff` 0
  - `borrow_out` 0
  - `overflow` 0
  - `busy` 0
  - internal counter and borrow flop 0
- Reset wins over every other event on the same edge. A reset during RUN or DONE aborts the operation: no `out_valid` is issued and the pending result is lost.
- Latency: `out_valid` rises on the WIDTH-th rising edge after the accepting edge (8 edges for WIDTH = 8).
- Throughput: with `out_ready` tied high, one result every WIDTH+2 edges. This covers the accept edge, WIDTH RUN edges, and the DONE transfer edge; `in_ready` returns the cycle after the transfer.
- There is no combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`. All outputs are registered or decoded directly from the state.
- Backpressure: DONE may persist indefinitely. Outputs must not change while `out_ready` = 0.

## Test plan
- WIDTH = 8, `a` = 0x5A, `b` = 0x1F, `out_ready` = 1.
  - Result: `diff` = 0x3B, `borrow_out` = 0, `overflow` = 0.
  - `out_valid` is high exactly 8 edges after the accept edge, for one cycle.
- `a` = 0x00, `b` = 0x01 -> `diff` = 0xFF, `borrow_out` = 1, `overflow` = 0.
- Two signed-overflow cases:
  - `a` = 0x80, `b` = 0x01 -> `diff` = 0x7F, `borrow_out` = 0, `overflow` = 1.
  - `a` = 0x7F, `b` = 0xFF -> `diff` = 0x80, `borrow_out` = 1, `overflow` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles after `out_valid` rises, and drive `in_valid` = 1 with new operands.
  - `diff`, `borrow_out` and `overflow` stay stable.
  - `in_ready` stays 0, and the second pair is not accepted until the cycle after `out_ready` = 1.
  - The second result arrives correctly.
- Back-to-back stream of 4 pairs, including `a` = `b` = 0xAA (result 0x00, `borrow_out` 0):
  - Results arrive in order, spaced exactly 10 edges apart.
- Reset mid-run: assert `rst` for one cycle on the 3rd RUN edge.
  - Next cycle: `in_ready` = 1, `busy` = 0, `out_valid` = 0, all outputs 0.
  - `out_valid` never asserts for the aborted pair, and the next pair computes correctly.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor computing diff = a - b (mod 2^WIDTH), LSB first,
//   one bit per clock through a single full-subtractor cell and a borrow flop.
//   Operands and results move through valid/ready handshakes.
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous reset, active-high
//   in_valid    operand pair valid
//   in_ready    block can accept operands (IDLE only)
//   a, b        minuend / subtrahend, sampled on the input handshake
//   out_valid   result valid (DONE only)
//   out_ready   downstream accepts the result
//   diff        (a - b) mod 2^WIDTH
//   borrow_out  final borrow, 1 when a < b unsigned
//   overflow    signed overflow of the subtraction
//   busy        high while an operation is in flight (RUN or DONE)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             overflow_r;
  logic             d_s;
  logic             br_nxt_s;
  logic             ovf_s;
  logic             last_bit_s;

  // Full-subtractor difference bit.
  function automatic logic fs_diff(input logic a_bit, input logic b_bit, input logic br_in);
    return a_bit ^ b_bit ^ br_in;
  endfunction

  // Full-subtractor borrow out.
  function automatic logic fs_borrow(input logic a_bit, input logic b_bit, input logic br_in);
    return (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_in);
  endfunction

  // Single full-subtractor cell acting on the current operand LSBs.
  always_comb begin
    d_s        = fs_diff(a_sh_r[0], b_sh_r[0], br_r);
    br_nxt_s   = fs_borrow(a_sh_r[0], b_sh_r[0], br_r);
    // On the final bit the operand LSBs are the sign bits and d_s is the result sign.
    ovf_s      = (a_sh_r[0] ^ b_sh_r[0]) & (d_s ^ a_sh_r[0]);
    last_bit_s = (cnt_r == LAST_CNT);
  end

  // Result bits enter from the MSB side so the first computed bit ends at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_nxt_s = d_s;
    end else begin : g_res_wn
      assign res_nxt_s = {d_s, res_r[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; handshakes depend only on registered state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: operand shifters, result shifter, bit counter, borrow and overflow.
  // The result shifter doubles as the diff output register and the borrow flop
  // as borrow_out; both are don't-care outside DONE and frozen in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r     <= '0;
      b_sh_r     <= '0;
      res_r      <= '0;
      cnt_r      <= '0;
      br_r       <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh_r <= a;
            b_sh_r <= b;
            cnt_r  <= '0;
            br_r   <= 1'b0;
          end
        end
        ST_RUN: begin
          a_sh_r <= a_sh_r >> 1;
          b_sh_r <= b_sh_r >> 1;
          res_r  <= res_nxt_s;
          cnt_r  <= cnt_r + CW'(1);
          br_r   <= br_nxt_s;
          if (last_bit_s) begin
            overflow_r <= ovf_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready   = (state_r == ST_IDLE);
  assign out_valid  = (state_r == ST_DONE);
  assign busy       = (state_r != ST_IDLE);
  assign diff       = res_r;
  assign borrow_out = br_r;
  assign overflow   = overflow_r;

endmodule
